mul16_seq_ctrl: RTL
===================

Name: mul16_seq_ctrl

Overview:
- Sequential unsigned 16x16 -> 32-bit multiplier controller built around one shared 16-bit ripple-carry adder.
- Sequences the adder through 16 shift-and-add iterations using a start/busy/done handshake.
- Sits beside the adder in the arithmetic datapath. Gives multiply capability without a combinational array multiplier.

Parameters:
- WIDTH, 16, operand width. Only 16 is supported; the product is 2*WIDTH bits.
- CNT_W, 5, iteration counter width. Must hold the value WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- start  input  1  request a multiply. Accepted only in IDLE or DONE.
- a  input  16  multiplicand, sampled on the accepted start.
- b  input  16  multiplier, sampled on the accepted start.
- product  output  32  result a*b. Registered; held until the next result is written.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when product is updated.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low: rst_n sampled low at a rising clk edge resets the block.
- Reset values:
  - state = IDLE.
  - product = 0, busy = 0, done = 0.
  - Internal M, HI, LO = 0; cnt = 0.
- Internal registers:
  - M[15:0]: latched multiplicand.
  - HI[15:0]: upper accumulator.
  - LO[15:0]: multiplier / lower product.
  - cnt[CNT_W-1:0]: iteration counter.
- Adder connection: a = HI, b = LO[0] ? M : 16'h0, carry_in = 0. Outputs are sum[15:0] and carry_out.
- State IDLE:
  - busy = 0, done = 0.
  - On start = 1: M <= a, HI <= 0, LO <= b, cnt <= 0; go to RUN.
  - Otherwise stay in IDLE.
- State RUN (busy = 1), each cycle:
  - {HI, LO} <= {carry_out, sum, LO[15:1]}. This is a 33-bit right shift of {carry, sum, LO}.
  - cnt <= cnt + 1.
  - On the 16th RUN cycle (cnt == 15): product <= next {HI, LO} value; go to DONE.
- State DONE:
  - busy = 0, done = 1 for exactly this cycle.
  - On start = 1: accepted exactly as in IDLE; go to RUN. This allows back-to-back operations.
  - Otherwise go to IDLE.
- Latency: start accepted at edge t. RUN occupies edges t+1..t+16. done and the new product are visible after edge t+16 and are high for the cycle ending at edge t+17. Throughput is one multiply per 17 cycles.
- Operand handling: a and b are ignored except on an accepted start. Changes during RUN have no effect.
- start while busy: ignored. Not queued, no error.
- product: changes only on the RUN->DONE transition and on reset. It holds its old value throughout a new RUN.
- Arithmetic: unsigned. Carry out of the adder is never lost; it shifts into HI[15]. Full range gives 0xFFFF * 0xFFFF = 0xFFFE0001.
- Reset mid-RUN: the operation is abandoned, all outputs return to 0, state = IDLE. A start in the same cycle as rst_n = 0 is ignored.
- Zero operands: still take the full 16 iterations. No early termination.

Test Plan:
- Reset, then a = 3, b = 5, start for 1 cycle -> busy high for 16 cycles. Then done = 1 for 1 cycle with product = 0x0000000F.
- a = 0xFFFF, b = 0xFFFF -> product = 0xFFFE0001 at done. Checks carry propagation through HI on every iteration.
- a = 0x1234, b = 0; then a = 0, b = 0xABCD -> product = 0 both times, each after 16 busy cycles.
- a = 0x00FF, b = 0x0101 started. Assert start with a = 0x7, b = 0x7 on RUN cycle 5 -> start ignored, product = 0x0000FFFF. Changing a/b mid-RUN must not alter the result.
- Back-to-back: a = 2, b = 3, with start held high through the done cycle and a = 0x100, b = 0x100 presented then -> first done gives 6. The second op starts with no IDLE cycle; done 17 cycles later gives 0x00010000.
- Start a = 0xFFFF, b = 2. Drive rst_n = 0 on RUN cycle 8 -> next cycle busy = 0, done = 0, product = 0. A new start a = 4, b = 4 after release gives 0x10.

Source files
------------

// File: rtl/mul16_seq_ctrl.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one shared ripple-carry adder
// stepped through WIDTH shift-and-add iterations under a start/busy/done handshake.

module mul16_rca #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);
    logic [W:0] c;
    assign c[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co = c[W];
endmodule

module mul16_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   m, hi, lo;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   addend, sum;
    logic               carry;
    logic [2*WIDTH-1:0] acc_nxt;

    assign addend  = lo[0] ? m : '0;
    // 33-bit right shift of {carry, sum, lo}: the carry lands in hi's MSB.
    assign acc_nxt = {carry, sum, lo[WIDTH-1:1]};

    mul16_rca #(.W(WIDTH)) u_add (
        .x  (hi),
        .y  (addend),
        .ci (1'b0),
        .s  (sum),
        .co (carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            m       <= '0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    busy <= start;
                    if (start) begin
                        m     <= a;
                        hi    <= '0;
                        lo    <= b;
                        cnt   <= '0;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    {hi, lo} <= acc_nxt;
                    cnt      <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        product <= acc_nxt;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule
